// File: rtl/mem_stage_pipe.sv
// Pipelined memory stage: stage-A op register feeding a RAM access and PC resolve,
// then an output register with valid/ready backpressure and saturating ld/st counters.
module mem_stage_pipe #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int PW    = 8,
    parameter int DEPTH = 256,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] pc_inc,
    input  logic [PW-1:0] pc_alu,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          pcsrc,
    input  logic          mem_wr,
    input  logic          mem_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] pc_out,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] alu_out,
    output logic          addr_err,
    output logic [CW-1:0] ld_count,
    output logic [CW-1:0] st_count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [PW-1:0] pc_inc;
        logic [PW-1:0] pc_alu;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          pcsrc;
        logic          mem_wr;
        logic          mem_rd;
    } op_t;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] rd_data;
        logic [DW-1:0] alu;
        logic          addr_err;
    } res_t;

    // vld_pipe[0] = stage A valid, vld_pipe[1] = output valid
    logic [1:0]    vld_pipe;
    op_t           op_a;
    res_t          res_q, res_d;
    logic [DW-1:0] ram [DEPTH];

    logic          stall, adv, oor_a, rd_hit, wr_hit;
    logic [IW-1:0] idx_a;

    assign stall    = vld_pipe[1] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // Widen by one bit so DEPTH == 2**AW is representable.
    assign oor_a  = ({1'b0, op_a.addr} >= (AW+1)'(DEPTH));
    assign idx_a  = op_a.addr[IW-1:0];
    assign rd_hit = adv & vld_pipe[0] & op_a.mem_rd & ~oor_a;
    assign wr_hit = adv & vld_pipe[0] & op_a.mem_wr & ~oor_a;

    always_comb begin
        res_d          = '0;
        res_d.pc       = op_a.pcsrc ? op_a.pc_alu : op_a.pc_inc;
        res_d.alu      = DW'(op_a.addr);
        res_d.addr_err = oor_a & (op_a.mem_rd | op_a.mem_wr);
        // Read is combinational, so a simultaneous store returns the old word.
        res_d.rd_data  = (op_a.mem_rd & ~oor_a) ? ram[idx_a] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            op_a     <= '0;
            res_q    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[0], in_valid};
            op_a     <= '{pc_inc: pc_inc, pc_alu: pc_alu, addr: addr, wdata: wdata,
                          pcsrc: pcsrc, mem_wr: mem_wr, mem_rd: mem_rd};
            // Bubbles leave the previous result fields untouched.
            if (vld_pipe[0])
                res_q <= res_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                ram[i] <= '0;
        end else if (wr_hit) begin
            ram[idx_a] <= op_a.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_count <= '0;
            st_count <= '0;
        end else begin
            if (rd_hit && ld_count != '1)
                ld_count <= ld_count + 1'b1;
            if (wr_hit && st_count != '1)
                st_count <= st_count + 1'b1;
        end
    end

    assign out_valid = vld_pipe[1];
    assign pc_out    = res_q.pc;
    assign rd_data   = res_q.rd_data;
    assign alu_out   = res_q.alu;
    assign addr_err  = res_q.addr_err;

endmodule
